// File: rtl/dh_cipher_core_if.sv
// Operand/result handshake bundle for the DH cipher stage: in_valid/in_ready carry operands in,
// out_valid/out_ready carry the result out. The master side is upstream, the slave side is the core.
interface dh_cipher_core_if #(
    parameter int DW = 64,
    parameter int PW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [DW-1:0] exp;
  logic [PW-1:0] p;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;
  logic [DW-1:0] c1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] c2;
  logic [DW-1:0] key;
  logic          match;
  logic          err_div0;

  modport master (
    output in_valid, mode, exp, p, r1, r2, c1, out_ready,
    input  in_ready, out_valid, c2, key, match, err_div0
  );

  modport slave (
    input  in_valid, mode, exp, p, r1, r2, c1, out_ready,
    output in_ready, out_valid, c2, key, match, err_div0
  );
endinterface

// File: rtl/dh_cipher_core.sv
// DH cipher stage: key = exp mod p by bit-serial restoring reduction, optional verify, c2 = key^r1.
// Latency accept->out_valid is DW+1 cycles (1 cycle when p==0); the result is held until out_ready.
module dh_cipher_core #(
    parameter  int DW = 64,
    parameter  int PW = 32,
    localparam int CW = $clog2(DW)
) (
    input logic             clk,
    input logic             rst,
    dh_cipher_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REDUCE, CHECK, OUT} state_t;

  state_t        state, state_nxt;
  logic          rdy_en;
  logic          mode_q;
  logic          div0_q;
  logic [DW-1:0] exp_q, r1_q, r2_q, c1_q;
  logic [PW-1:0] p_q;
  logic [PW:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] c2_q, key_q;
  logic          match_q, err_q, out_valid_q;

  logic          accept;
  logic [PW:0]   rem_shift, rem_nxt;
  logic [DW-1:0] key_calc;
  logic          match_calc;

  // in_ready stays low for the first cycle after reset release
  assign bus.in_ready  = (state == IDLE) && rdy_en;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c2        = c2_q;
  assign bus.key       = key_q;
  assign bus.match     = match_q;
  assign bus.err_div0  = err_q;

  // rem < p always holds after each step, so PW+1 bits never overflow
  assign rem_shift  = {rem_q[PW-1:0], exp_q[cnt_q]};
  assign rem_nxt    = (rem_shift >= {1'b0, p_q}) ? rem_shift - {1'b0, p_q} : rem_shift;
  assign key_calc   = DW'(rem_q[PW-1:0]);
  assign match_calc = ((key_calc ^ c1_q) == r2_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.p == '0) ? CHECK : REDUCE;
      REDUCE:  if (cnt_q == '0) state_nxt = CHECK;
      CHECK:   state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en      <= 1'b0;
      mode_q      <= 1'b0;
      div0_q      <= 1'b0;
      exp_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      c1_q        <= '0;
      p_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      c2_q        <= DW'(4'hF);
      key_q       <= '0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q <= bus.mode;
            div0_q <= (bus.p == '0);
            exp_q  <= bus.exp;
            r1_q   <= bus.r1;
            r2_q   <= bus.r2;
            c1_q   <= bus.c1;
            p_q    <= bus.p;
            rem_q  <= '0;
            cnt_q  <= CW'(DW - 1);
          end
        end
        REDUCE: begin
          rem_q <= rem_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        CHECK: begin
          out_valid_q <= 1'b1;
          if (div0_q) begin
            err_q   <= 1'b1;
            c2_q    <= '0;
            key_q   <= '0;
            match_q <= 1'b0;
          end else begin
            key_q   <= key_calc;
            match_q <= match_calc;
            // verify mode suppresses the ciphertext when the peer check fails
            c2_q    <= (mode_q && !match_calc) ? '0 : (key_calc ^ r1_q);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            c2_q        <= DW'(4'hF);
            err_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_cipher_core.sv
// Scoreboard bench for dh_cipher_core: expected results are queued at drive time
// and popped when out_valid appears; latency, hold-under-backpressure and reset abort are checked.
module tb_dh_cipher_core;

  localparam int DW = 64;
  localparam int PW = 32;

  typedef struct {
    logic [DW-1:0] c2;
    logic [DW-1:0] key;
    logic          match;
    logic          err;
    int            lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  dh_cipher_core_if #(.DW(DW), .PW(PW)) bus ();

  dh_cipher_core #(.DW(DW), .PW(PW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.exp       = '0;
    bus.p         = '0;
    bus.r1        = '0;
    bus.r2        = '0;
    bus.c1        = '0;
  endtask

  // Present operands and wait for the accept edge; returns with the bench #1 after that edge.
  task automatic drive_op(input logic m, input logic [DW-1:0] e, input logic [PW-1:0] pp,
                          input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                          input logic [DW-1:0] cc1, input bit score);
    exp_t x;
    int   n;
    x.key   = (pp == '0) ? '0 : e % DW'(pp);
    x.match = (pp != '0) && ((x.key ^ cc1) == a2);
    x.c2    = (pp == '0) ? '0 : ((m && !x.match) ? '0 : (x.key ^ a1));
    x.err   = (pp == '0);
    x.lat   = (pp == '0) ? 1 : DW + 1;
    if (score) sb.push_back(x);
    bus.in_valid = 1'b1;
    bus.mode = m; bus.exp = e; bus.p = pp; bus.r1 = a1; bus.r2 = a2; bus.c1 = cc1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", DW'(n), '0);
    @(posedge clk); #1;
    // operands change after acceptance and must not affect the result
    bus.in_valid = 1'b0;
    bus.mode = ~m;
    bus.exp = {$urandom, $urandom};
    bus.p   = $urandom;
    bus.r1  = {$urandom, $urandom};
    bus.r2  = {$urandom, $urandom};
    bus.c1  = {$urandom, $urandom};
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t x;
    int   lat;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_lat"}, DW'(lat), DW'(x.lat));
    chk({tag, "_key"}, bus.key, x.key);
    chk({tag, "_match"}, DW'(bus.match), DW'(x.match));
    chk({tag, "_c2"}, bus.c2, x.c2);
    chk({tag, "_err"}, DW'(bus.err_div0), DW'(x.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, DW'(bus.out_valid), 1);
      chk({tag, "_hold_c2"}, bus.c2, x.c2);
      chk({tag, "_hold_rdy"}, DW'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_done_vld"}, DW'(bus.out_valid), 0);
    chk({tag, "_done_c2"}, bus.c2, DW'(4'hF));
    chk({tag, "_done_err"}, DW'(bus.err_div0), 0);
    chk({tag, "_done_rdy"}, DW'(bus.in_ready), 1);
  endtask

  initial begin
    int seen;
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    rst = 1'b0;
    #23;
    chk("rst_vld", DW'(bus.out_valid), 0);
    chk("rst_c2", bus.c2, DW'(4'hF));
    chk("rst_key", bus.key, 0);
    chk("rst_match", DW'(bus.match), 0);
    chk("rst_err", DW'(bus.err_div0), 0);
    chk("rst_rdy", DW'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_rdy_pre", DW'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("rel_rdy_post", DW'(bus.in_ready), 1);

    drive_op(1'b1, 64'd100, 32'd7, 64'h10, 64'h7, 64'h5, 1'b1);
    collect("verify_ok", 0);
    drive_op(1'b1, 64'd100, 32'd7, 64'h10, 64'h8, 64'h5, 1'b1);
    collect("verify_bad", 0);
    drive_op(1'b0, 64'd100, 32'd7, 64'h10, 64'h8, 64'h5, 1'b1);
    collect("enc_only", 0);
    drive_op(1'b1, 64'h1234_5678_9ABC_DEF0, 32'd0, 64'h1, 64'h2, 64'h3, 1'b1);
    collect("div0", 0);
    drive_op(1'b0, 64'd5, 32'd7, 64'hA5, 64'h0, 64'h0, 1'b1);
    collect("exp_lt_p", 0);
    drive_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'h0, 64'h0, 1'b1);
    collect("ones_pmax", 0);
    drive_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFE, 64'h0, 64'h0, 64'h0, 1'b1);
    collect("ones_pmax_m1", 10);
    drive_op(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 32'h8000_0001, 64'hCAFE, 64'h0, 64'h0, 1'b1);
    collect("back2back", 0);
    for (int i = 0; i < 3; i++) begin
      drive_op(i[0], {$urandom, $urandom}, 32'($urandom) | 32'h1, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      collect("rand", i);
    end

    drive_op(1'b1, 64'd100, 32'd7, 64'h10, 64'h7, 64'h5, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_vld", DW'(bus.out_valid), 0);
    chk("abort_c2", bus.c2, DW'(4'hF));
    chk("abort_key", bus.key, 0);
    chk("abort_rdy", DW'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_spurious", DW'(seen), 0);
    drive_op(1'b1, 64'd100, 32'd7, 64'h10, 64'h7, 64'h5, 1'b1);
    collect("after_abort", 0);

    chk("sb_drained", DW'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
